// File: rtl/weight_load_ctrl.sv
// Weight buffer load sequencer: counts stream bytes into words, drives the buffer's
// write strobe/pointers in kernel-major order, and steps the conv-engine read address.
module weight_load_ctrl #(
   parameter int CH_MAX = 8,
   parameter int DEPTH  = 256,
   parameter int CW     = $clog2(CH_MAX),
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic          sclk,
   input  logic          s_rst,
   input  logic          cfg_start,
   input  logic          cfg_conv_type,
   input  logic [CW:0]   cfg_ch_num,
   input  logic [AW:0]   cfg_kernel_num,
   input  logic          weight_data_in_vld,
   input  logic          rd_start,
   input  logic          rd_next,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [CW-1:0] ch_cnt,
   output logic          conv_type,
   output logic [AW-1:0] wbuffer_rd_addr,
   output logic          rd_last,
   output logic          load_busy,
   output logic          load_done,
   output logic          weight_ready,
   output logic          err_overflow,
   output logic [1:0]    fsm_state
);

   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, READY = 2'd2} state_t;

   state_t        state;
   logic [CW:0]   ch_num_r;
   logic [AW:0]   kernel_num_r;
   logic [3:0]    byte_cnt;

   logic          in_load, start_acc, byte_ok, word_done;
   logic          ch_wrap, pend_last;
   logic [CW-1:0] adv_ch, pend_ch;
   logic [AW-1:0] adv_addr, pend_addr, rd_nxt;
   logic [AW:0]   kn_nxt;

   assign fsm_state = state;

   always_comb begin
      in_load   = (state == LOAD);
      start_acc = cfg_start & ~in_load;
      // Bytes arriving during the final write cycle belong to no word.
      byte_ok   = in_load & weight_data_in_vld & ~load_done;
      word_done = byte_ok & ((byte_cnt == 4'd8) | conv_type);

      ch_wrap  = ({1'b0, ch_cnt} == ch_num_r - 1'b1);
      adv_ch   = ch_wrap ? '0 : ch_cnt + 1'b1;
      adv_addr = ch_wrap ? wr_addr + 1'b1 : wr_addr;

      // Pointer the word just completed will be written to: if a write is in
      // flight this cycle, the pointers move at this same edge.
      pend_ch   = wr_en ? adv_ch : ch_cnt;
      pend_addr = wr_en ? adv_addr : wr_addr;
      pend_last = ({1'b0, pend_ch} == ch_num_r - 1'b1) &
                  ({1'b0, pend_addr} == kernel_num_r - 1'b1);

      rd_nxt = wbuffer_rd_addr;
      if (weight_ready) begin
         if (rd_start)
            rd_nxt = '0;
         else if (rd_next)
            rd_nxt = ({1'b0, wbuffer_rd_addr} == kernel_num_r - 1'b1) ? '0 : wbuffer_rd_addr + 1'b1;
      end
      kn_nxt = start_acc ? cfg_kernel_num : kernel_num_r;
   end

   always_ff @(posedge sclk or posedge s_rst) begin
      if (s_rst) begin
         state           <= IDLE;
         ch_num_r        <= '0;
         kernel_num_r    <= '0;
         byte_cnt        <= '0;
         wr_en           <= 1'b0;
         wr_addr         <= '0;
         ch_cnt          <= '0;
         conv_type       <= 1'b0;
         wbuffer_rd_addr <= '0;
         rd_last         <= 1'b0;
         load_busy       <= 1'b0;
         load_done       <= 1'b0;
         weight_ready    <= 1'b0;
         err_overflow    <= 1'b0;
      end else begin
         wr_en     <= word_done;
         load_done <= word_done & pend_last;

         if (weight_data_in_vld & (~in_load | load_done))
            err_overflow <= 1'b1;

         if (byte_ok)
            byte_cnt <= word_done ? 4'd0 : byte_cnt + 4'd1;

         if (wr_en) begin
            if (load_done) begin
               state        <= READY;
               wr_addr      <= '0;
               ch_cnt       <= '0;
               weight_ready <= 1'b1;
               load_busy    <= 1'b0;
            end else begin
               wr_addr <= adv_addr;
               ch_cnt  <= adv_ch;
            end
         end

         if (start_acc) begin
            state        <= LOAD;
            conv_type    <= cfg_conv_type;
            ch_num_r     <= cfg_ch_num;
            kernel_num_r <= cfg_kernel_num;
            byte_cnt     <= '0;
            wr_addr      <= '0;
            ch_cnt       <= '0;
            weight_ready <= 1'b0;
            load_busy    <= 1'b1;
         end

         wbuffer_rd_addr <= rd_nxt;
         rd_last         <= ({1'b0, rd_nxt} == kn_nxt - 1'b1);
      end
   end

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Directed bench for weight_load_ctrl: drivers push expected writes (cycle, addr,
// ch, done) into a queue; a negedge monitor pops and checks every wr_en.
module tb_weight_load_ctrl;

   logic       sclk = 1'b0;
   logic       s_rst;
   logic       cfg_start = 1'b0;
   logic       cfg_conv_type = 1'b0;
   logic [3:0] cfg_ch_num = 4'd0;
   logic [8:0] cfg_kernel_num = 9'd0;
   logic       weight_data_in_vld = 1'b0;
   logic       rd_start = 1'b0;
   logic       rd_next = 1'b0;
   logic       wr_en;
   logic [7:0] wr_addr;
   logic [2:0] ch_cnt;
   logic       conv_type;
   logic [7:0] wbuffer_rd_addr;
   logic       rd_last;
   logic       load_busy;
   logic       load_done;
   logic       weight_ready;
   logic       err_overflow;
   logic [1:0] fsm_state;

   weight_load_ctrl dut (
      .sclk(sclk), .s_rst(s_rst),
      .cfg_start(cfg_start), .cfg_conv_type(cfg_conv_type),
      .cfg_ch_num(cfg_ch_num), .cfg_kernel_num(cfg_kernel_num),
      .weight_data_in_vld(weight_data_in_vld),
      .rd_start(rd_start), .rd_next(rd_next),
      .wr_en(wr_en), .wr_addr(wr_addr), .ch_cnt(ch_cnt), .conv_type(conv_type),
      .wbuffer_rd_addr(wbuffer_rd_addr), .rd_last(rd_last),
      .load_busy(load_busy), .load_done(load_done), .weight_ready(weight_ready),
      .err_overflow(err_overflow), .fsm_state(fsm_state)
   );

   // ---------------- clock / reset ----------------
   always #5 sclk = ~sclk;

   int unsigned cyc = 0;
   always @(posedge sclk) cyc <= cyc + 1;

   // ---------------- scoreboard ----------------
   // entry = {expected cycle[15:0], wr_addr[7:0], ch_cnt[2:0], load_done}
   logic [27:0] exp_q[$];
   int          vec_cnt = 0;
   int          miscompares = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   always @(negedge sclk) begin
      logic [27:0] got, exp;
      if (!s_rst && wr_en) begin
         got = {cyc[15:0], wr_addr, ch_cnt, load_done};
         vec_cnt++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL wr_unexpected: cyc=%0d addr=%0d ch=%0d done=%0d, no write expected",
                     cyc, wr_addr, ch_cnt, load_done);
         end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
               miscompares++;
               $display("FAIL wr_word: got cyc=%0d addr=%0d ch=%0d done=%0d expected cyc=%0d addr=%0d ch=%0d done=%0d",
                        got[27:12], got[11:4], got[3:1], got[0], exp[27:12], exp[11:4], exp[3:1], exp[0]);
            end
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic tick();
      @(posedge sclk);
      #1;
   endtask

   task automatic start_cfg(input logic ct, input int ch, input int kn);
      cfg_conv_type  = ct;
      cfg_ch_num     = 4'(ch);
      cfg_kernel_num = 9'(kn);
      cfg_start      = 1'b1;
      tick();
      cfg_start      = 1'b0;
   endtask

   // Streams nbytes with gap idle cycles between bytes; word k goes to (k/ch, k%ch).
   task automatic load(input logic ct, input int ch, input int kn, input int nbytes, input int gap);
      int bpw, words, k;
      bpw   = ct ? 1 : 9;
      words = ch * kn;
      k     = 0;
      start_cfg(ct, ch, kn);
      for (int b = 0; b < nbytes; b++) begin
         weight_data_in_vld = 1'b1;
         if (((b + 1) % bpw) == 0 && k < words) begin
            exp_q.push_back({16'(cyc + 1), 8'(k / ch), 3'(k % ch), (k == words - 1)});
            k++;
         end
         tick();
         weight_data_in_vld = 1'b0;
         repeat (gap) tick();
      end
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
         @(posedge sclk);
         #2;
      end
      chk("drain", exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic rd_pulse(input logic st, input logic nx);
      rd_start = st;
      rd_next  = nx;
      tick();
      rd_start = 1'b0;
      rd_next  = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      s_rst = 1'b1;
      repeat (3) tick();
      chk("rst_wr_en", wr_en, 0);
      chk("rst_busy", load_busy, 0);
      chk("rst_ready", weight_ready, 0);
      chk("rst_err", err_overflow, 0);
      chk("rst_rd_addr", wbuffer_rd_addr, 0);
      chk("rst_state", fsm_state, 0);
      s_rst = 1'b0;
      tick();

      // read side ignored while not ready
      rd_pulse(1'b0, 1'b1);
      chk("rd_ignored", wbuffer_rd_addr, 0);

      // 3x3, 2 channels x 2 kernels, continuous stream
      start_cfg(1'b0, 2, 2);
      chk("busy_in_load", load_busy, 1);
      chk("state_load", fsm_state, 1);
      s_rst = 1'b0;
      begin
         int k;
         k = 0;
         for (int b = 0; b < 36; b++) begin
            weight_data_in_vld = 1'b1;
            if (((b + 1) % 9) == 0) begin
               exp_q.push_back({16'(cyc + 1), 8'(k / 2), 3'(k % 2), (k == 3)});
               k++;
            end
            tick();
         end
         weight_data_in_vld = 1'b0;
      end
      wait_drain(20);
      chk("t1_ready", weight_ready, 1);
      chk("t1_busy", load_busy, 0);
      chk("t1_ptr", {wr_addr, ch_cnt}, 0);
      chk("t1_state", fsm_state, 2);
      chk("t1_conv_type", conv_type, 0);

      // stray byte in READY: no write, sticky error
      chk("err_before", err_overflow, 0);
      weight_data_in_vld = 1'b1;
      tick();
      weight_data_in_vld = 1'b0;
      tick();
      chk("err_ready_byte", err_overflow, 1);

      // 3x3 with gaps (1 byte every 3 cycles); error survives cfg_start
      load(1'b0, 1, 2, 18, 2);
      chk("err_sticky", err_overflow, 1);
      wait_drain(20);
      chk("t3_ready", weight_ready, 1);

      // 1x1, kernel_num=3, then read stepping
      load(1'b1, 1, 3, 3, 0);
      wait_drain(20);
      chk("t5_ready", weight_ready, 1);
      chk("t5_conv_type", conv_type, 1);
      rd_pulse(1'b1, 1'b0);
      chk("rd_addr0", wbuffer_rd_addr, 0);
      chk("rd_last0", rd_last, 0);
      rd_pulse(1'b0, 1'b1);
      chk("rd_addr1", wbuffer_rd_addr, 1);
      chk("rd_last1", rd_last, 0);
      rd_pulse(1'b0, 1'b1);
      chk("rd_addr2", wbuffer_rd_addr, 2);
      chk("rd_last2", rd_last, 1);
      rd_pulse(1'b0, 1'b1);
      chk("rd_wrap", wbuffer_rd_addr, 0);
      chk("rd_last_wrap", rd_last, 0);
      rd_pulse(1'b1, 1'b1);
      chk("rd_start_wins", wbuffer_rd_addr, 0);
      rd_pulse(1'b0, 1'b1);
      chk("rd_addr_again", wbuffer_rd_addr, 1);

      // reset after 5 of 9 bytes: outputs clear asynchronously
      load(1'b0, 1, 1, 5, 0);
      chk("mid_busy", load_busy, 1);
      #2;
      s_rst = 1'b1;
      #1;
      chk("arst_busy", load_busy, 0);
      chk("arst_err", err_overflow, 0);
      chk("arst_rd_addr", wbuffer_rd_addr, 0);
      chk("arst_state", fsm_state, 0);
      tick();
      s_rst = 1'b0;
      tick();
      chk("arst_ready", weight_ready, 0);
      load(1'b0, 2, 1, 18, 0);
      wait_drain(20);
      chk("t6_ready", weight_ready, 1);

      // 1x1, 8 channels x 256 kernels back-to-back
      load(1'b1, 8, 256, 2048, 0);
      wait_drain(20);
      chk("t2_ready", weight_ready, 1);
      chk("t2_ptr", {wr_addr, ch_cnt}, 0);
      chk("t2_err", err_overflow, 0);

      repeat (3) tick();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
      $finish;
   end

endmodule
